// File: rtl/memory_stage.sv
// MEM pipeline stage: word-addressed 32-bit data memory with a fixed access latency.
// One access at a time; `active` covers the busy window so the hazard unit can stall.
module memory_stage #(
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RegWriteM,
    input  logic        MemToRegM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] writeDataM,
    input  logic [4:0]  WriteRegM,
    output logic        active,
    output logic [31:0] readDataM
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;

    logic              state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [31:0]       data_q, data_d;
    logic              is_store_q, is_store_d;
    logic              active_q, active_d;
    logic [31:0]       rdata_q;
    logic [31:0]       mem_q [DEPTH];

    logic request;
    logic complete;

    // Pipeline bookkeeping fields pass through this stage untouched.
    logic unused_inputs;
    assign unused_inputs = ^{RegWriteM, WriteRegM, ALUOutM[31:ADDR_W]};

    assign request  = MemToRegM | MemWriteM;
    assign complete = (state_q == ST_BUSY) && (cnt_q == 4'd0);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        data_d     = data_q;
        is_store_d = is_store_q;
        active_d   = active_q;
        case (state_q)
            ST_IDLE: begin
                if (request) begin
                    state_d    = ST_BUSY;
                    cnt_d      = 4'(LATENCY - 1);
                    idx_d      = ALUOutM[ADDR_W-1:0];
                    data_d     = writeDataM;
                    is_store_d = MemWriteM;
                    active_d   = 1'b1;
                end
            end
            default: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d  = ST_IDLE;
                    active_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            idx_q      <= '0;
            data_q     <= 32'd0;
            is_store_q <= 1'b0;
            active_q   <= 1'b0;
            rdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            is_store_q <= is_store_d;
            active_q   <= active_d;
            if (complete && !is_store_q) begin
                rdata_q <= mem_q[idx_q];
            end
        end
    end

    // Reset clears the whole array and drops any store still in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else if (complete && is_store_q) begin
            mem_q[idx_q] <= data_q;
        end
    end

    assign active    = active_q;
    assign readDataM = rdata_q;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed table, multi-cycle corner sequences,
// and randomized accesses checked against an array model of the data memory.
module tb_memory_stage;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_write;
    logic [31:0] alu_out;
    logic [31:0] write_data;
    logic [4:0]  write_reg;
    logic        active;
    logic [31:0] read_data;

    always #5 clk = ~clk;

    memory_stage #(
        .DEPTH(256),
        .ADDR_W(8),
        .LATENCY(LAT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .RegWriteM(reg_write),
        .MemToRegM(mem_to_reg),
        .MemWriteM(mem_write),
        .ALUOutM(alu_out),
        .writeDataM(write_data),
        .WriteRegM(write_reg),
        .active(active),
        .readDataM(read_data)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] model_mem [256];
    logic [31:0] model_rd;

    typedef struct {
        bit          st;
        bit          ld;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) model_mem[i] = 32'd0;
        model_rd = 32'd0;
    endtask

    // One access from IDLE: request edge, LAT busy edges, with junk on the inputs while busy.
    task automatic run_access(input bit st, input bit ld, input logic [31:0] addr,
                              input logic [31:0] data, input logic [31:0] exp_rd, input string name);
        mem_to_reg = ld;
        mem_write  = st;
        alu_out    = addr;
        write_data = data;
        reg_write  = 1'($urandom);
        write_reg  = 5'($urandom);
        tick();
        for (int k = 0; k < LAT; k++) begin
            check({name, " active busy"}, {31'd0, active}, 32'd1);
            check({name, " rd held busy"}, read_data, model_rd);
            mem_to_reg = 1'($urandom);
            mem_write  = 1'($urandom);
            alu_out    = $urandom;
            write_data = $urandom;
            tick();
        end
        check({name, " active done"}, {31'd0, active}, 32'd0);
        check({name, " readDataM"}, read_data, exp_rd);
        mem_to_reg = 1'b0;
        mem_write  = 1'b0;
        if (st) model_mem[addr[7:0]] = data;
        model_rd = exp_rd;
        $display("txn %s st=%0b ld=%0b addr=%h data=%h rd=%h exp=%h",
                 name, st, ld, addr, data, read_data, exp_rd);
    endtask

    initial begin
        rst_n      = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b1;
        mem_write  = 1'b0;
        alu_out    = 32'd5;
        write_data = 32'd0;
        write_reg  = 5'd0;
        model_reset();

        // Reset held with a load request pending.
        for (int k = 0; k < 2; k++) begin
            tick();
            check("reset active", {31'd0, active}, 32'd0);
            check("reset readDataM", read_data, 32'd0);
        end
        rst_n = 1'b1;
        run_access(1'b0, 1'b1, 32'd5, 32'd0, 32'd0, "load5_after_reset");

        // Continuous load request: active period LAT+1, readDataM stays 0.
        mem_to_reg = 1'b1;
        mem_write  = 1'b0;
        alu_out    = 32'd1;
        write_data = 32'd1;
        write_reg  = 5'd0;
        reg_write  = 1'b1;
        for (int k = 0; k < 3 * (LAT + 1); k++) begin
            tick();
            check("continuous active", {31'd0, active}, ((k % (LAT + 1)) != LAT) ? 32'd1 : 32'd0);
            check("continuous readDataM", read_data, 32'd0);
        end
        mem_to_reg = 1'b0;
        $display("txn continuous_load done");

        vecs[0] = '{1'b1, 1'b0, 32'h0000_0003, 32'hDEAD_BEEF, 32'h0000_0000};
        vecs[1] = '{1'b0, 1'b1, 32'h0000_0003, 32'h1111_1111, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0007, 32'h1234_5678, 32'hDEAD_BEEF};
        vecs[3] = '{1'b0, 1'b1, 32'h0000_0007, 32'h0000_0000, 32'h1234_5678};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0101, 32'hA5A5_A5A5, 32'h1234_5678};
        vecs[5] = '{1'b0, 1'b1, 32'h0000_0001, 32'h0000_0000, 32'hA5A5_A5A5};
        vecs[6] = '{1'b0, 1'b1, 32'hFFFF_FF03, 32'h0000_0000, 32'hDEAD_BEEF};
        vecs[7] = '{1'b0, 1'b1, 32'h0000_00C8, 32'h0000_0000, 32'h0000_0000};
        for (int i = 0; i < 8; i++) begin
            run_access(vecs[i].st, vecs[i].ld, vecs[i].addr, vecs[i].data, vecs[i].exp_rd,
                       $sformatf("vec%0d", i));
        end

        // Reset while a store is in flight: the store must be dropped.
        mem_write  = 1'b1;
        mem_to_reg = 1'b0;
        alu_out    = 32'd9;
        write_data = 32'hFFFF_FFFF;
        tick();
        check("midstore active", {31'd0, active}, 32'd1);
        rst_n     = 1'b0;
        mem_write = 1'b0;
        tick();
        check("midstore reset active", {31'd0, active}, 32'd0);
        check("midstore reset readDataM", read_data, 32'd0);
        rst_n = 1'b1;
        model_reset();
        $display("txn reset_mid_store done");
        run_access(1'b0, 1'b1, 32'd9, 32'd0, 32'd0, "load9_after_reset");
        run_access(1'b0, 1'b1, 32'd3, 32'd0, 32'd0, "load3_after_reset");

        // Randomized accesses against the array model, with idle gaps.
        for (int i = 0; i < 40; i++) begin
            bit          st;
            bit          ld;
            logic [31:0] addr;
            logic [31:0] data;
            logic [31:0] exp_rd;
            int          gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                tick();
                check("idle active", {31'd0, active}, 32'd0);
                check("idle readDataM", read_data, model_rd);
            end
            st     = 1'($urandom);
            ld     = st ? 1'($urandom) : 1'b1;
            addr   = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 15));
            data   = $urandom;
            exp_rd = st ? model_rd : model_mem[addr[7:0]];
            run_access(st, ld, addr, data, exp_rd, $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
